mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, shall set the byte address width.
REQ-002 Parameter DW, default 8, shall set the data width in bits.
REQ-003 Parameter MEM_LAT, default 1, legal range 1..4, shall set the memory read latency in cycles.
REQ-004 clk  in  1  shall be the single clock; all state shall update on its rising edge.
REQ-005 rst  in  1  shall be the reset: synchronous, active-low.
REQ-006 cpu_req  in  1  shall be the CPU access request.
REQ-007 cpu_we, cpu_addr[AW], cpu_wdata[DW]  in  shall carry the CPU write flag, address and write data.
REQ-008 cpu_gnt  out  1  shall be a one-cycle accept pulse; cpu_rvalid out 1 and cpu_rdata out DW shall carry the read-return pulse and data.
REQ-009 host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata shall be the identical port set for the loader/debug host.
REQ-010 mem_en, mem_we out 1, mem_addr out AW, mem_wdata out DW shall drive the single shared memory port; mem_rdata in DW shall be the memory read data.

Function
REQ-011 FSM states shall be IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: if any req is high, the FSM shall select a winner, latch its we/addr/wdata and go to ISSUE; otherwise it shall stay in IDLE.
REQ-013 ISSUE shall last exactly one cycle: mem_en=1, mem_we, mem_addr and mem_wdata driven from the latched values, and the winner's gnt=1.
REQ-014 After ISSUE, a write shall go to IDLE; a read shall go to WAIT.
REQ-015 WAIT shall last exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1 in ISSUE; mem_rdata shall be captured on the edge ending the last WAIT cycle.
REQ-016 RESP shall last one cycle: the winner's rvalid=1 and rdata = captured value; then the FSM shall go to IDLE.
REQ-017 Read latency from the first req-high cycle in IDLE to rvalid shall be MEM_LAT+2 cycles; write acceptance shall be 1 cycle (gnt in the following cycle).
REQ-018 Arbitration shall be two-way round-robin: on simultaneous requests, the requester not granted most recently shall win; a single requester shall always win.
REQ-019 The last-grant register shall update only in ISSUE.
REQ-020 No requester shall wait more than one complete foreign transaction after raising req.
REQ-021 Requesters shall hold req and its fields stable until gnt; the arbiter shall sample req only in IDLE.
REQ-022 Outside ISSUE, mem_en and mem_we shall be 0; outside RESP, both rvalid outputs shall be 0; rdata outputs shall hold their last value.
REQ-023 Gnt and rvalid shall never be high for both requesters in the same cycle.
REQ-024 A req dropped in a non-IDLE state shall not affect the transaction in flight.

Reset
REQ-025 With rst=0 at a clock edge: state shall become IDLE, the WAIT counter 0, and the last-grant register HOST, so the CPU wins the first tie.
REQ-026 On that edge, all gnt, rvalid, mem_en and mem_we outputs shall be 0; mem_addr, mem_wdata and both rdata outputs shall be 0.
REQ-027 Reset in ISSUE, WAIT or RESP shall abort the transaction; no rvalid shall follow for it.

Structure
REQ-028 Shared package tinymips_pkg shall hold the arbiter state encoding (2-bit), the requester ID encoding (CPU=0, HOST=1) and the MEM_LAT default.
REQ-029 One sub-module, rr_arb2, shall be used: a combinational two-way round-robin picker (inputs: two reqs, last-grant; output: winner ID, valid).
REQ-030 All outputs shall be driven from registers or from decoded state only, with no combinational path from req to mem_*.

Verification
REQ-031 Scenario: MEM_LAT=1, CPU read addr 0x10 with memory holding 0xA5 -> cpu_gnt at T+1, cpu_rvalid at T+3 with cpu_rdata=0xA5, and host outputs all 0.
REQ-032 Scenario: host write 0x3C to 0x20, then CPU read of 0x20 -> mem_we=1 for exactly one cycle, and cpu_rdata=0x3C.
REQ-033 Scenario: both reqs held high for 4 transactions from reset -> grant order CPU, HOST, CPU, HOST.
REQ-034 Scenario: MEM_LAT=4, host read -> exactly 4 WAIT cycles, and host_rvalid 6 cycles after req.
REQ-035 Scenario: rst=0 in the second WAIT cycle of a CPU read -> IDLE next cycle, no cpu_rvalid, and the next tie goes to CPU.
REQ-036 Scenario: CPU req held through a host transaction -> cpu_gnt within one transaction, and gnt/rvalid never both high.

Source files
------------

// File: rtl/tinymips_pkg.sv
// Shared types and constants for the tinymips memory arbiter.
package tinymips_pkg;

  // Default read latency of the shared memory, in cycles (legal 1..4).
  localparam int unsigned MemLatDefault = 1;

  // Width of the WAIT down-counter; holds MEM_LAT-1 for MEM_LAT up to 4.
  localparam int unsigned CntW = 2;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Requester identity.
  typedef enum logic {
    IdCpu  = 1'b0,
    IdHost = 1'b1
  } req_id_e;

  // The requester that is not the given one.
  function automatic req_id_e other_id(input req_id_e id);
    return (id == IdCpu) ? IdHost : IdCpu;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not granted most recently wins; a lone requester always wins.
module rr_arb2
  import tinymips_pkg::*;
(
  input  logic    req_cpu,
  input  logic    req_host,
  input  req_id_e last_gnt,
  output req_id_e winner,
  output logic    valid
);

  // Pick the winner from the two requests and the last-grant history.
  always_comb begin
    valid  = req_cpu | req_host;
    winner = IdCpu;
    if (req_cpu && req_host) begin
      winner = other_id(last_gnt);
    end else if (req_host) begin
      winner = IdHost;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a loader/debug host onto one shared memory port.
// Every output is a register written by the FSM, so no combinational path
// runs from a requester to the memory port.
module mem_arbiter
  import tinymips_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = MemLatDefault
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  req_id_e         last_gnt_q;
  req_id_e         txn_id_q;
  logic            txn_we_q;

  req_id_e         pick_id;
  logic            pick_valid;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_cpu  (cpu_req),
    .req_host (host_req),
    .last_gnt (last_gnt_q),
    .winner   (pick_id),
    .valid    (pick_valid)
  );

  // Route the winner's command fields towards the latch.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick_id == IdHost) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end
  end

  // Arbiter FSM with registered outputs; mem_addr/mem_wdata double as the
  // latched command and hold their value between transactions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_gnt_q  <= IdHost;
      txn_id_q    <= IdCpu;
      txn_we_q    <= 1'b0;
      cpu_gnt     <= 1'b0;
      host_gnt    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      // Pulse outputs default low; only one state raises each of them.
      cpu_gnt     <= 1'b0;
      host_gnt    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q   <= StIssue;
            txn_id_q  <= pick_id;
            txn_we_q  <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cpu_gnt   <= (pick_id == IdCpu);
            host_gnt  <= (pick_id == IdHost);
          end
        end
        StIssue: begin
          last_gnt_q <= txn_id_q;
          if (txn_we_q) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
            cnt_q   <= CntW'(MEM_LAT - 1);
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
            if (txn_id_q == IdCpu) begin
              cpu_rdata  <= mem_rdata;
              cpu_rvalid <= 1'b1;
            end else begin
              host_rdata  <= mem_rdata;
              host_rvalid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
